// File: rtl/aesl_deadlock_detect_unit_if.sv
// Signal bundle between one per-process deadlock detector and the monitor network.
// The master side drives process status and token control; the slave side is the detector.
interface aesl_deadlock_detect_unit_if #(
    parameter int PROC_NUM = 4
);
    logic                proc_blocked;
    logic [PROC_NUM-1:0] dep_vec;
    logic [PROC_NUM-1:0] suspect_vec;
    logic                dl_detect_in;
    logic [PROC_NUM-1:0] origin;
    logic                token_in;
    logic                token_clear;
    logic                suspect_out;
    logic                dl_out;
    logic [PROC_NUM-1:0] token_out;
    logic                loop_err;

    modport master (
        output proc_blocked, dep_vec, suspect_vec, dl_detect_in, origin, token_in, token_clear,
        input  suspect_out, dl_out, token_out, loop_err
    );

    modport slave (
        input  proc_blocked, dep_vec, suspect_vec, dl_detect_in, origin, token_in, token_clear,
        output suspect_out, dl_out, token_out, loop_err
    );
endinterface

// File: rtl/aesl_deadlock_detect_unit.sv
// Per-process deadlock detector: times out a stalled process, flags a closed wait cycle,
// then walks the dependence chain with a one-hot token after global detection.
module aesl_deadlock_detect_unit #(
    parameter int PROC_NUM = 4,
    parameter int PROC_ID  = 0,
    parameter int TIMEOUT  = 16
) (
    input logic                          clock,
    input logic                          reset,
    aesl_deadlock_detect_unit_if.slave   bus
);
    localparam int                  CNT_W   = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0]    CNT_MAX = CNT_W'(TIMEOUT);
    localparam logic [PROC_NUM-1:0] SELF    = PROC_NUM'(1) << PROC_ID;

    typedef enum logic [2:0] {IDLE, BLOCKED, SUSPECT, FROZEN, TOKEN} state_t;

    state_t              state, state_nxt;
    logic [CNT_W-1:0]    cnt;
    logic                suspect_q, suspect_nxt;
    logic                dl_q, dl_nxt;
    logic [PROC_NUM-1:0] token_q, token_nxt;
    logic                loop_q, loop_nxt;
    logic                visited, visited_nxt;
    logic                origin_flag, origin_flag_nxt;

    logic [PROC_NUM-1:0] dep_others;
    logic [PROC_NUM-1:0] cand;
    logic [PROC_NUM-1:0] succ;
    logic                closed;

    // Own bit never counts as a dependence; successor is the lowest suspect we wait on.
    assign dep_others = bus.dep_vec & ~SELF;
    assign cand       = dep_others & bus.suspect_vec;
    assign succ       = cand & (~cand + PROC_NUM'(1));
    assign closed     = (dep_others != '0) && ((dep_others & ~bus.suspect_vec) == '0);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
        end else if (!bus.proc_blocked) begin
            cnt <= '0;
        end else if (cnt != CNT_MAX) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            suspect_q   <= 1'b0;
            dl_q        <= 1'b0;
            token_q     <= '0;
            loop_q      <= 1'b0;
            visited     <= 1'b0;
            origin_flag <= 1'b0;
        end else begin
            state       <= state_nxt;
            suspect_q   <= suspect_nxt;
            dl_q        <= dl_nxt;
            token_q     <= token_nxt;
            loop_q      <= loop_nxt;
            visited     <= visited_nxt;
            origin_flag <= origin_flag_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (bus.proc_blocked) state_nxt = BLOCKED;
            BLOCKED: begin
                if (!bus.proc_blocked)   state_nxt = IDLE;
                else if (cnt == CNT_MAX) state_nxt = SUSPECT;
            end
            SUSPECT: begin
                if (bus.dl_detect_in)       state_nxt = FROZEN;
                else if (!bus.proc_blocked) state_nxt = IDLE;
            end
            FROZEN: begin
                // Clear and origin seed both outrank an arriving token.
                if (!bus.dl_detect_in)                              state_nxt = IDLE;
                else if (!bus.token_clear && !bus.origin[PROC_ID] && bus.token_in)
                                                                    state_nxt = TOKEN;
            end
            TOKEN:   state_nxt = bus.dl_detect_in ? FROZEN : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        dl_nxt          = 1'b0;
        token_nxt       = '0;
        loop_nxt        = loop_q;
        visited_nxt     = visited;
        origin_flag_nxt = origin_flag;
        suspect_nxt     = (state_nxt == SUSPECT) || (state_nxt == FROZEN) || (state_nxt == TOKEN);

        if (state == SUSPECT && state_nxt == SUSPECT) begin
            dl_nxt = closed;
        end else if (state == FROZEN || state == TOKEN) begin
            if (!bus.dl_detect_in || bus.token_clear) begin
                visited_nxt     = 1'b0;
                origin_flag_nxt = 1'b0;
            end else if (state == FROZEN && bus.origin[PROC_ID]) begin
                origin_flag_nxt = 1'b1;
                visited_nxt     = 1'b1;
                token_nxt       = succ;
            end else if (state == FROZEN && bus.token_in) begin
                dl_nxt = 1'b1;
                if (origin_flag) begin
                    token_nxt = '0;
                end else if (visited) begin
                    loop_nxt = 1'b1;
                end else begin
                    visited_nxt = 1'b1;
                    token_nxt   = succ;
                end
            end
        end
    end

    assign bus.suspect_out = suspect_q;
    assign bus.dl_out      = dl_q;
    assign bus.token_out   = token_q;
    assign bus.loop_err    = loop_q;
endmodule
